change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter COIN_HI, default 10: value in credit units of the large coin.
REQ-002 Parameter COIN_MID, default 5: value in credit units of the mid coin; the small coin is fixed at 1 unit.
REQ-003 Legal parameters SHALL satisfy COIN_HI > COIN_MID > 1 and COIN_HI <= 31.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 clear  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request to dispense `amount`; sampled only in IDLE.
REQ-007 amount  in  5  change owed in credit units, 0..31.
REQ-008 coin_ready  in  1  coin mechanism accepts the offered coin this cycle.
REQ-009 coin_valid  out  1  a coin is offered.
REQ-010 coin_type  out  2  offered coin: 00 none, 01 one-unit, 10 mid, 11 high.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 done  out  1  one-cycle pulse when the dispense completes.
REQ-013 remaining  out  5  credit units still to dispense.
REQ-014 coins_out  out  5  count of coins handed over in the current or last dispense.

Function
REQ-015 The FSM SHALL have the states IDLE, DISPENSE and DONE.
REQ-016 IDLE with start=1 at edge k SHALL load remaining=amount and coins_out=0, and the next state SHALL be DISPENSE if amount!=0, else DONE.
REQ-017 start SHALL be ignored in DISPENSE and DONE, and amount SHALL be sampled only on the accepting edge.
REQ-018 In DISPENSE, coin_valid SHALL be 1 and coin_type SHALL select the largest coin whose value is <= remaining.
REQ-019 Outputs SHALL be decoded from registered state only, so there is no combinational path from any input to any output.
REQ-020 coin_valid and coin_type SHALL hold stable until a handshake (coin_valid & coin_ready) occurs at an edge.
REQ-021 On a handshake, remaining SHALL decrease by the coin value, coins_out SHALL increment, and the next state SHALL be DONE if the new remaining is 0, else DISPENSE.
REQ-022 With coin_ready held high, one coin SHALL transfer per cycle, and the first coin SHALL be offered in the cycle after the accepting edge.
REQ-023 coin_ready SHALL be ignored while coin_valid=0.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-025 In IDLE, coins_out and remaining SHALL hold their final values until the next accepted start.
REQ-026 Subtraction SHALL never underflow, because coin selection guarantees coin value <= remaining.
REQ-027 The sum of coin values dispensed SHALL equal the latched amount.
REQ-028 Outside DISPENSE, coin_valid SHALL be 0 and coin_type SHALL be 00.

Reset
REQ-029 clear=1 at an edge SHALL force state=IDLE, remaining=0, coins_out=0, coin_valid=0, coin_type=00, busy=0 and done=0, regardless of the other inputs.
REQ-030 clear SHALL take priority over start and over a simultaneous handshake.
REQ-031 A clear that aborts a dispense SHALL produce no done pulse.

Structure
REQ-032 The shared package vending_pkg SHALL hold the coin_type encoding constants, the FSM state enum, and the default coin values.
REQ-033 Largest-coin selection SHALL be the single sub-module coin_select: input remaining and outputs coin_type and coin value, purely combinational.
REQ-034 Registers for state, remaining and coins_out SHALL live in change_dispenser.

Verification
REQ-035 amount=27 with ready always high -> coins 11,11,10,01,01 on 5 consecutive cycles; done pulses the cycle after the last handshake; coins_out=5; remaining=0.
REQ-036 amount=0 -> no coin_valid; done=1 in the cycle after the start edge; busy is high for that cycle only.
REQ-037 amount=15 with coin_ready low for 3 cycles -> coin_valid=1 and coin_type=11 held stable for those 3 cycles; then coins 11,10 transfer and done pulses.
REQ-038 start with amount=4 while busy during an amount=31 dispense -> ignored; output is 11,11,11,01 and coins_out=4.
REQ-039 clear asserted after the 2nd handshake of amount=27 -> next cycle shows all outputs 0 and no done pulse; a new start with amount=6 yields 10,01.
REQ-040 Simultaneous clear and handshake -> the reset result wins, and coins_out stays 0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: coin encodings, FSM states and default coin values.
package vending_pkg;

  localparam int unsigned AMT_W        = 5;
  localparam int unsigned COIN_HI_DEF  = 10;
  localparam int unsigned COIN_MID_DEF = 5;

  typedef enum logic [1:0] {
    CT_NONE = 2'b00,
    CT_ONE  = 2'b01,
    CT_MID  = 2'b10,
    CT_HI   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DISPENSE = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

endpackage

// File: rtl/coin_select.sv
// Picks the largest coin whose value does not exceed the credit still owed.
module coin_select
  import vending_pkg::*;
#(
  parameter int unsigned COIN_HI  = COIN_HI_DEF,
  parameter int unsigned COIN_MID = COIN_MID_DEF
) (
  input  logic [AMT_W-1:0] remaining,
  output coin_e            coin_type,
  output logic [AMT_W-1:0] coin_val
);

  always_comb begin
    coin_type = CT_NONE;
    coin_val  = '0;
    if (remaining >= AMT_W'(COIN_HI)) begin
      coin_type = CT_HI;
      coin_val  = AMT_W'(COIN_HI);
    end else if (remaining >= AMT_W'(COIN_MID)) begin
      coin_type = CT_MID;
      coin_val  = AMT_W'(COIN_MID);
    end else if (remaining != '0) begin
      coin_type = CT_ONE;
      coin_val  = AMT_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Dispenses a latched amount as a greedy sequence of coins over a valid/ready handshake.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned COIN_HI  = COIN_HI_DEF,
  parameter int unsigned COIN_MID = COIN_MID_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coins_out
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  coin_e            type_q, type_d;
  logic [AMT_W-1:0] val_q, val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  coin_e            sel_type;
  logic [AMT_W-1:0] sel_val;

  // Selection runs on the next remaining value so the offered coin is ready as a register.
  coin_select #(
    .COIN_HI  (COIN_HI),
    .COIN_MID (COIN_MID)
  ) u_coin_select (
    .remaining (rem_d),
    .coin_type (sel_type),
    .coin_val  (sel_val)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      type_q  <= CT_NONE;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = amount;
          cnt_d   = '0;
          state_d = (amount != '0) ? ST_DISPENSE : ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (valid_q && coin_ready) begin
          rem_d = rem_q - val_q;
          cnt_d = cnt_q + AMT_W'(1);
          if (rem_q == val_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    valid_d = (state_d == ST_DISPENSE);
    type_d  = valid_d ? sel_type : CT_NONE;
    val_d   = valid_d ? sel_val : '0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  assign coin_valid = valid_q;
  assign coin_type  = type_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign remaining  = rem_q;
  assign coins_out  = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scenario and randomized checks of change_dispenser against a greedy coin-list model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [4:0] amount;
  logic       coin_ready;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       busy;
  logic       done;
  logic [4:0] remaining;
  logic [4:0] coins_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .COIN_HI  (10),
    .COIN_MID (5)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .amount     (amount),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .coins_out  (coins_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed output snapshot: {valid, type, busy, done, remaining, coins_out}.
  function automatic logic [14:0] obs();
    return {coin_valid, coin_type, busy, done, remaining, coins_out};
  endfunction

  function automatic logic [14:0] exp_vec(logic v, logic [1:0] t, logic b, logic d,
                                          int unsigned r, int unsigned c);
    return {v, t, b, d, 5'(r), 5'(c)};
  endfunction

  function automatic int unsigned coin_value(logic [1:0] t);
    case (t)
      2'b11:   return 10;
      2'b10:   return 5;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  // Reference: greedy change as a list of coin codes.
  function automatic void make_coins(int unsigned amt, output logic [1:0] q[$]);
    int unsigned r = amt;
    q = {};
    while (r > 0) begin
      if (r >= 10)     begin q.push_back(2'b11); r -= 10; end
      else if (r >= 5) begin q.push_back(2'b10); r -= 5;  end
      else             begin q.push_back(2'b01); r -= 1;  end
    end
  endfunction

  task automatic test_reset();
    clear = 1'b1; start = 1'b1; amount = 5'd9; coin_ready = 1'b1;
    tick();
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs(), 15'h0);
    end
    tick();
    clear = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs(), 15'h0);
    end
  endtask

  task automatic test_amount27();
    logic [1:0] q[$];
    int unsigned r = 27;
    make_coins(27, q);
    coin_ready = 1'b1; start = 1'b1; amount = 5'd27;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (obs() !== exp_vec(1'b1, q[i], 1'b1, 1'b0, r, i)) begin
        miscompares++;
        $display("FAIL amt27_coin%0d: got %h want %h", i, obs(), exp_vec(1'b1, q[i], 1'b1, 1'b0, r, i));
      end
      r -= coin_value(q[i]);
      tick();
    end
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 5)) begin
      miscompares++;
      $display("FAIL amt27_done: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 5));
    end
    tick();
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 5)) begin
      miscompares++;
      $display("FAIL amt27_idle: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 5));
    end
  endtask

  task automatic test_zero();
    coin_ready = 1'b1; start = 1'b1; amount = 5'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 0)) begin
      miscompares++;
      $display("FAIL zero_done: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 0));
    end
    tick();
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 0)) begin
      miscompares++;
      $display("FAIL zero_idle: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 0));
    end
  endtask

  task automatic test_stall15();
    coin_ready = 1'b0; start = 1'b1; amount = 5'd15;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs() !== exp_vec(1'b1, 2'b11, 1'b1, 1'b0, 15, 0)) begin
        miscompares++;
        $display("FAIL stall15_hold%0d: got %h want %h", i, obs(), exp_vec(1'b1, 2'b11, 1'b1, 1'b0, 15, 0));
      end
      tick();
    end
    coin_ready = 1'b1;
    vectors++;
    if (obs() !== exp_vec(1'b1, 2'b11, 1'b1, 1'b0, 15, 0)) begin
      miscompares++;
      $display("FAIL stall15_hi: got %h want %h", obs(), exp_vec(1'b1, 2'b11, 1'b1, 1'b0, 15, 0));
    end
    tick();
    vectors++;
    if (obs() !== exp_vec(1'b1, 2'b10, 1'b1, 1'b0, 5, 1)) begin
      miscompares++;
      $display("FAIL stall15_mid: got %h want %h", obs(), exp_vec(1'b1, 2'b10, 1'b1, 1'b0, 5, 1));
    end
    tick();
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 2)) begin
      miscompares++;
      $display("FAIL stall15_done: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 2));
    end
    tick();
  endtask

  task automatic test_ignore_start();
    logic [1:0] want[4] = '{2'b11, 2'b11, 2'b11, 2'b01};
    int unsigned r = 31;
    coin_ready = 1'b1; start = 1'b1; amount = 5'd31;
    tick();
    amount = 5'd4;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs() !== exp_vec(1'b1, want[i], 1'b1, 1'b0, r, i)) begin
        miscompares++;
        $display("FAIL ignore_start_coin%0d: got %h want %h", i, obs(), exp_vec(1'b1, want[i], 1'b1, 1'b0, r, i));
      end
      r -= coin_value(want[i]);
      tick();
    end
    start = 1'b0;
    vectors++;
    if (obs() !== exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 4)) begin
      miscompares++;
      $display("FAIL ignore_start_done: got %h want %h", obs(), exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, 4));
    end
    tick();
  endtask

  task automatic test_clear_abort();
    coin_ready = 1'b1; start = 1'b1; amount = 5'd27;
    tick();
    start = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL clear_abort: got %h want %h", obs(), 15'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_abort_nodone%0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    start = 1'b1; amount = 5'd6;
    tick();
    start = 1'b0;
    vectors++;
    if (obs() !== exp_vec(1'b1, 2'b10, 1'b1, 1'b0, 6, 0)) begin
      miscompares++;
      $display("FAIL after_clear_mid: got %h want %h", obs(), exp_vec(1'b1, 2'b10, 1'b1, 1'b0, 6, 0));
    end
    tick();
    vectors++;
    if (obs() !== exp_vec(1'b1, 2'b01, 1'b1, 1'b0, 1, 1)) begin
      miscompares++;
      $display("FAIL after_clear_one: got %h want %h", obs(), exp_vec(1'b1, 2'b01, 1'b1, 1'b0, 1, 1));
    end
    tick();
    tick();
  endtask

  task automatic test_clear_handshake();
    coin_ready = 1'b1; start = 1'b1; amount = 5'd15;
    tick();
    start = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL clear_handshake: got %h want %h", obs(), 15'h0);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  q[$];
    int unsigned amt, r, cnt, budget, sum;
    for (int n = 0; n < 40; n++) begin
      amt = $urandom_range(0, 31);
      make_coins(amt, q);
      start = 1'b1; amount = 5'(amt); coin_ready = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0; amount = 5'($urandom_range(0, 31));
      r = amt; cnt = 0; budget = 0; sum = 0;
      while (q.size() > 0 && budget < 200) begin
        vectors++;
        if (obs() !== exp_vec(1'b1, q[0], 1'b1, 1'b0, r, cnt)) begin
          miscompares++;
          $display("FAIL rand%0d_coin: amt=%0d got %h want %h", n, amt, obs(), exp_vec(1'b1, q[0], 1'b1, 1'b0, r, cnt));
        end
        coin_ready = ($urandom_range(0, 3) != 0);
        start = 1'($urandom_range(0, 1));
        tick();
        if (coin_ready) begin
          r   -= coin_value(q[0]);
          sum += coin_value(q[0]);
          cnt++;
          void'(q.pop_front());
        end
        budget++;
      end
      start = 1'b0;
      vectors++;
      if (budget >= 200 || sum != amt) begin
        miscompares++;
        $display("FAIL rand%0d_budget: cycles=%0d sum=%0d want sum %0d", n, budget, sum, amt);
      end
      vectors++;
      if (obs() !== exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, cnt)) begin
        miscompares++;
        $display("FAIL rand%0d_done: amt=%0d got %h want %h", n, amt, obs(), exp_vec(1'b0, 2'b00, 1'b1, 1'b1, 0, cnt));
      end
      coin_ready = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (obs() !== exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, cnt)) begin
        miscompares++;
        $display("FAIL rand%0d_idle: amt=%0d got %h want %h", n, amt, obs(), exp_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, cnt));
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; amount = '0; coin_ready = 1'b0;
    test_reset();
    test_amount27();
    test_zero();
    test_stall15();
    test_ignore_start();
    test_clear_abort();
    test_clear_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
